// File: rtl/pattern_player.sv
// pattern_player: plays a latched list of 2-bit LED selects on four one-hot
// LEDs, each step lit for an on-time and followed by a dark gap, then pulses
// o_done so the game controller can switch to input capture.
// Optional feature macro: PATTERN_PLAYER_SPEEDUP_EN (halves the on-time for
// long patterns, i.e. effective level > MAX_LEN/2).
//
// Handshake: i_start is a one-cycle request that is accepted only while the
// FSM is IDLE (o_busy low, o_done low); o_done is a one-cycle completion
// pulse and a new i_start is accepted in the cycle right after it. i_abort
// overrides everything, including a simultaneous i_start.
module pattern_player #(
  parameter int MAX_LEN    = 16,
  parameter int ON_CYCLES  = 12_500_000,
  parameter int GAP_CYCLES = 6_250_000,
  parameter int LEVEL_W    = $clog2(MAX_LEN + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [LEVEL_W-1:0]   i_level,
  input  logic [2*MAX_LEN-1:0] i_pattern,
  output logic [3:0]           o_led,
  output logic [LEVEL_W-1:0]   o_step,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [1:0]           o_state
);

  localparam int CNT_MAX = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [CNT_W-1:0]   ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]   GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [LEVEL_W-1:0] LVL_MAX  = LEVEL_W'(MAX_LEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [LEVEL_W-1:0]          step_q, step_d;
  logic [LEVEL_W-1:0]          level_q, level_d;
  logic [MAX_LEN-1:0][1:0]     pattern_q, pattern_d;
  logic [3:0]                  led_q, led_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic [LEVEL_W-1:0]          eff_level;
  logic [CNT_W-1:0]            on_last;

  // Requested level clamped to the pattern storage depth.
  assign eff_level = (i_level > LVL_MAX) ? LVL_MAX : i_level;

`ifdef PATTERN_PLAYER_SPEEDUP_EN
  localparam logic [CNT_W-1:0]   ON_LAST_FAST = CNT_W'(ON_CYCLES / 2 - 1);
  localparam logic [LEVEL_W-1:0] LVL_HALF     = LEVEL_W'(MAX_LEN / 2);
  logic fast_q, fast_d;
  assign on_last = fast_q ? ON_LAST_FAST : ON_LAST;
`else
  assign on_last = ON_LAST;
`endif

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    step_d    = step_q;
    level_d   = level_q;
    pattern_d = pattern_q;
`ifdef PATTERN_PLAYER_SPEEDUP_EN
    fast_d    = fast_q;
`endif
    case (state_q)
      S_IDLE: begin
        step_d = '0;
        cnt_d  = '0;
        if (i_start) begin
          pattern_d = i_pattern;
          level_d   = eff_level;
`ifdef PATTERN_PLAYER_SPEEDUP_EN
          fast_d    = (eff_level > LVL_HALF);
`endif
          state_d   = (eff_level != '0) ? S_ON : S_DONE;
        end
      end
      S_ON: begin
        if (cnt_q == on_last) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (step_q + LEVEL_W'(1) == level_q) begin
            state_d = S_DONE;
          end else begin
            step_d  = step_q + LEVEL_W'(1);
            state_d = S_ON;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        step_d  = '0;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        step_d  = '0;
        cnt_d   = '0;
      end
    endcase

    // Abort beats everything; the latched pattern and level are kept as-is.
    if (i_abort) begin
      state_d   = S_IDLE;
      step_d    = '0;
      cnt_d     = '0;
      pattern_d = pattern_q;
      level_d   = level_q;
`ifdef PATTERN_PLAYER_SPEEDUP_EN
      fast_d    = fast_q;
`endif
    end

    // Outputs are computed from next state so they come straight off flops.
    led_d  = (state_d == S_ON) ? (4'b0001 << pattern_d[step_d[IDX_W-1:0]]) : 4'b0000;
    busy_d = (state_d == S_ON) || (state_d == S_GAP);
    done_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      step_q    <= '0;
      level_q   <= '0;
      pattern_q <= '0;
      led_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef PATTERN_PLAYER_SPEEDUP_EN
      fast_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      level_q   <= level_d;
      pattern_q <= pattern_d;
      led_q     <= led_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef PATTERN_PLAYER_SPEEDUP_EN
      fast_q    <= fast_d;
`endif
    end
  end

  assign o_led   = led_q;
  assign o_step  = step_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_state = state_q;

endmodule

// File: tb/tb_pattern_player.sv
// tb_pattern_player: directed playback scenarios for pattern_player with
// MAX_LEN=8, ON_CYCLES=4, GAP_CYCLES=2. The driver pushes the expected
// per-cycle {led, busy, done, step} trace into a queue when it issues a
// start; a monitor pops one entry per cycle and compares.
module tb_pattern_player;

  localparam int MAX_LEN = 8;
  localparam int ON_C    = 4;
  localparam int GAP_C   = 2;
  localparam int LW      = $clog2(MAX_LEN + 1);
  localparam int W       = 4 + 1 + 1 + LW;
  localparam int NONE    = 1000000;

  logic                 clk;
  logic                 i_rst_n;
  logic                 i_start;
  logic                 i_abort;
  logic [LW-1:0]        i_level;
  logic [2*MAX_LEN-1:0] i_pattern;
  logic [3:0]           o_led;
  logic [LW-1:0]        o_step;
  logic                 o_busy;
  logic                 o_done;
  logic [1:0]           o_state;

  logic [W-1:0] exp_q[$];
  int           idx_q[$];
  string        cur_name;
  int           n_cmp;
  int           n_bad;

  pattern_player #(
    .MAX_LEN    (MAX_LEN),
    .ON_CYCLES  (ON_C),
    .GAP_CYCLES (GAP_C)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (i_rst_n),
    .i_start   (i_start),
    .i_abort   (i_abort),
    .i_level   (i_level),
    .i_pattern (i_pattern),
    .o_led     (o_led),
    .o_step    (o_step),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_state   (o_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want summary");
    $fatal(1);
  end

  // Expected outputs for cycle T+j of a playback started at edge T,
  // straight from the timing formula; cycles after kill are idle.
  function automatic logic [W-1:0] exp_at(input logic [2*MAX_LEN-1:0] pat,
                                          input int lvl, input int j, input int kill);
    int         l, on_t, p, k, off;
    logic [1:0] sel;
    logic [3:0] led;
    if (j > kill) return '0;
    l    = (lvl > MAX_LEN) ? MAX_LEN : lvl;
    on_t = ON_C;
`ifdef PATTERN_PLAYER_SPEEDUP_EN
    if (l > MAX_LEN / 2) on_t = ON_C / 2;
`endif
    p = on_t + GAP_C;
    if (j <= l * p) begin
      k   = (j - 1) / p;
      off = (j - 1) % p;
      sel = pat[2*k +: 2];
      led = (off < on_t) ? (4'b0001 << sel) : 4'b0000;
      return {led, 1'b1, 1'b0, LW'(k)};
    end
    if (j == l * p + 1) return {4'b0000, 1'b0, 1'b1, LW'(0)};
    return '0;
  endfunction

  // One playback: start at the current negedge, then n cycles with optional
  // ignored restart, abort or reset (cycle numbers relative to T; 0 = with start).
  task automatic play(input string name, input logic [2*MAX_LEN-1:0] pat, input int lvl,
                      input int abort_c, input int restart_c, input int rst_c, input int n);
    int kill;
    @(negedge clk);
    cur_name  = name;
    i_pattern = pat;
    i_level   = LW'(lvl);
    i_start   = 1'b1;
    i_abort   = (abort_c == 0);
    kill      = (abort_c < rst_c) ? abort_c : rst_c;
    for (int j = 1; j <= n; j++) begin
      exp_q.push_back(exp_at(pat, lvl, j, kill));
      idx_q.push_back(j);
    end
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      i_start   = (c == restart_c);
      i_abort   = (c == abort_c);
      i_rst_n   = !(c == rst_c);
      i_pattern = 16'($urandom);
      i_level   = LW'($urandom_range(0, 15));
    end
  endtask

  // Monitor: one comparison per cycle while expectations are queued.
  always @(posedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] act;
    int           j;
    #2;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      j   = idx_q.pop_front();
      act = {o_led, o_busy, o_done, o_step};
      n_cmp++;
      // Step index is not defined while o_done is high, so it is not checked there.
      if (act[W-1:LW] != e[W-1:LW] || (!e[LW] && act[LW-1:0] != e[LW-1:0])) begin
        n_bad++;
        $display("FAIL %s T+%0d: got led=%b busy=%b done=%b step=%0d, want led=%b busy=%b done=%b step=%0d",
                 cur_name, j, act[W-1:W-4], act[LW+1], act[LW], act[LW-1:0],
                 e[W-1:W-4], e[LW+1], e[LW], e[LW-1:0]);
      end
    end
  end

  // Stimulus sequence and final report.
  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    cur_name  = "reset";
    i_rst_n   = 1'b0;
    i_start   = 1'b1;
    i_abort   = 1'b0;
    i_level   = LW'(3);
    i_pattern = 16'h0032;
    // Reset held two cycles with start high, then three idle cycles after release.
    for (int j = 1; j <= 2; j++) begin
      exp_q.push_back('0);
      idx_q.push_back(j);
    end
    repeat (2) @(negedge clk);
    i_rst_n = 1'b1;
    i_start = 1'b0;
    for (int j = 3; j <= 5; j++) begin
      exp_q.push_back('0);
      idx_q.push_back(j);
    end
    repeat (3) @(negedge clk);

    // Steps {2,0,3}: pattern bits step2=11, step1=00, step0=10.
    play("lvl3",        16'h0032, 3,  NONE, 0, NONE, 21);
    play("lvl0",        16'h00FF, 0,  NONE, 0, NONE, 3);
    play("abort8",      16'h0032, 3,  8,    3, NONE, 14);
    play("clamp12",     16'hE4B1, 12, NONE, 0, NONE, 52);
    play("lvl5",        16'h1B4E, 5,  NONE, 0, NONE, 33);
    play("lvl4",        16'h00C9, 4,  NONE, 0, NONE, 27);
    play("abort_start", 16'h0033, 2,  0,    0, NONE, 5);
    play("abort_gap",   16'h0027, 2,  5,    0, NONE, 9);
    play("rst_mid",     16'h0039, 3,  NONE, 0, 5,    10);
    play("b2b_a",       16'h0002, 1,  NONE, 0, NONE, 7);
    play("b2b_b",       16'h0001, 1,  NONE, 0, NONE, 9);
    play("lvl8",        16'h6C93, 8,  NONE, 0, NONE, 50);

    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
